// File: rtl/bomb_engine.sv
// Bomb engine: owns the bomb map, accepts placements from two players and
// on every tick sweeps the map to advance fuses, detonate bombs, apply
// damage and decide the game outcome.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | accept placements, wait for a tick (or a pending one)
// SCAN    | visit one cell per cycle in row-major order, advance/detonate
// DAMAGE  | apply at most one point of damage per player, pulse explode
// RESOLVE | derive game_state from post-damage health, return to IDLE
module bomb_engine #(
  parameter int GRID_W      = 10,
  parameter int GRID_H      = 10,
  parameter int COORD_W     = 4,
  parameter int FUSE        = 3,
  parameter int RADIUS      = 2,
  parameter int HEALTH_W    = 2,
  parameter int HEALTH_INIT = 3
) (
  input  logic                         bombClk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         place_a_valid,
  output logic                         place_a_ready,
  input  logic                         place_b_valid,
  output logic                         place_b_ready,
  input  logic [COORD_W-1:0]           player_ax,
  input  logic [COORD_W-1:0]           player_ay,
  input  logic [COORD_W-1:0]           player_bx,
  input  logic [COORD_W-1:0]           player_by,
  input  logic [COORD_W-1:0]           rd_x,
  input  logic [COORD_W-1:0]           rd_y,
  output logic [$clog2(FUSE+1)-1:0]    rd_state,
  output logic                         rd_flame,
  output logic [HEALTH_W-1:0]          health_a,
  output logic [HEALTH_W-1:0]          health_b,
  output logic [1:0]                   game_state,
  output logic                         busy,
  output logic                         explode
);

  localparam int SW = $clog2(FUSE + 1);

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t     C_ONE   = coord_t'(1);
  localparam coord_t     X_LAST  = coord_t'(GRID_W - 1);
  localparam coord_t     Y_LAST  = coord_t'(GRID_H - 1);
  localparam coord_t     XI_MAX  = coord_t'(GRID_W - 2);
  localparam coord_t     YI_MAX  = coord_t'(GRID_H - 2);
  localparam coord_t     RAD     = coord_t'(RADIUS);
  localparam logic [SW-1:0] FUSE_V = SW'(FUSE);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DAMAGE, S_RESOLVE} state_t;

  state_t                r_state;
  state_t                w_next;

  logic [SW-1:0]         r_cell  [GRID_H][GRID_W];
  logic                  r_flame [GRID_H][GRID_W];
  coord_t                r_x;
  coord_t                r_y;
  logic                  r_pending;
  logic                  r_hit_a;
  logic                  r_hit_b;
  logic                  r_det;
  logic [HEALTH_W-1:0]   r_health_a;
  logic [HEALTH_W-1:0]   r_health_b;
  logic [1:0]            r_game;

  logic                  w_ready;
  logic                  w_start;
  logic                  w_last;
  logic                  w_border;
  logic [SW-1:0]         w_cur;
  logic [SW-1:0]         w_cell_a;
  logic [SW-1:0]         w_cell_b;
  logic                  w_in_a;
  logic                  w_in_b;
  logic                  w_acc_a;
  logic                  w_acc_b;
  logic                  w_rd_in;

  // Differences taken as max-min so they never wrap.
  function automatic coord_t absdiff(input coord_t a, input coord_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic in_cross(input coord_t px, input coord_t py,
                                    input coord_t cx, input coord_t cy);
    return ((px == cx) && (absdiff(py, cy) <= RAD)) ||
           ((py == cy) && (absdiff(px, cx) <= RAD));
  endfunction

  function automatic logic interior(input coord_t x, input coord_t y);
    return (x >= C_ONE) && (x <= XI_MAX) && (y >= C_ONE) && (y <= YI_MAX);
  endfunction

  // Placement acceptance, scan bookkeeping and the render read port.
  always_comb begin
    w_ready  = (r_state == S_IDLE) && (r_game == 2'd0);
    w_start  = w_ready && (tick || r_pending);
    w_last   = (r_x == X_LAST) && (r_y == Y_LAST);
    w_border = (r_x == '0) || (r_y == '0) || (r_x == X_LAST) || (r_y == Y_LAST);
    w_cur    = r_cell[r_y][r_x];
    w_in_a   = interior(player_ax, player_ay);
    w_in_b   = interior(player_bx, player_by);
    w_cell_a = w_in_a ? r_cell[player_ay][player_ax] : '0;
    w_cell_b = w_in_b ? r_cell[player_by][player_bx] : '0;
    w_acc_a  = place_a_valid && w_ready && w_in_a && (w_cell_a == '0);
    // A wins a same-cell collision, so B is dropped whenever A also asks there.
    w_acc_b  = place_b_valid && w_ready && w_in_b && (w_cell_b == '0) &&
               !(place_a_valid && (player_ax == player_bx) && (player_ay == player_by));
    w_rd_in  = (rd_x <= X_LAST) && (rd_y <= Y_LAST);
    rd_state = w_rd_in ? r_cell[rd_y][rd_x] : '0;
    rd_flame = w_rd_in ? r_flame[rd_y][rd_x] : 1'b0;
  end

  // FSM state register.
  always_ff @(posedge bombClk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state and handshake/status outputs.
  always_comb begin
    w_next        = r_state;
    place_a_ready = w_ready;
    place_b_ready = w_ready;
    busy          = (r_state != S_IDLE);
    explode       = 1'b0;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_SCAN;
      S_SCAN:    if (w_last)  w_next = S_DAMAGE;
      S_DAMAGE: begin
        explode = r_det;
        w_next  = S_RESOLVE;
      end
      S_RESOLVE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Map, flames, scan position, hit flags, health and game outcome.
  always_ff @(posedge bombClk) begin
    if (rst) begin
      for (int j = 0; j < GRID_H; j++) begin
        for (int i = 0; i < GRID_W; i++) begin
          r_cell[j][i]  <= '0;
          r_flame[j][i] <= 1'b0;
        end
      end
      r_x        <= '0;
      r_y        <= '0;
      r_pending  <= 1'b0;
      r_hit_a    <= 1'b0;
      r_hit_b    <= 1'b0;
      r_det      <= 1'b0;
      r_health_a <= HEALTH_W'(HEALTH_INIT);
      r_health_b <= HEALTH_W'(HEALTH_INIT);
      r_game     <= 2'd0;
    end else begin
      // Only one tick can be remembered while a sweep is in flight.
      if (tick && (r_state != S_IDLE)) r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_acc_a) r_cell[player_ay][player_ax] <= SW'(1);
          if (w_acc_b) r_cell[player_by][player_bx] <= SW'(1);
          if (w_start) begin
            for (int j = 0; j < GRID_H; j++) begin
              for (int i = 0; i < GRID_W; i++) r_flame[j][i] <= 1'b0;
            end
            r_x       <= '0;
            r_y       <= '0;
            r_hit_a   <= 1'b0;
            r_hit_b   <= 1'b0;
            r_det     <= 1'b0;
            r_pending <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_border) begin
            r_cell[r_y][r_x] <= '0;
          end else if (w_cur == FUSE_V) begin
            r_cell[r_y][r_x] <= '0;
            r_det            <= 1'b1;
            for (int j = 0; j < GRID_H; j++) begin
              for (int i = 0; i < GRID_W; i++) begin
                if (in_cross(coord_t'(i), coord_t'(j), r_x, r_y)) r_flame[j][i] <= 1'b1;
              end
            end
            if (in_cross(player_ax, player_ay, r_x, r_y)) r_hit_a <= 1'b1;
            if (in_cross(player_bx, player_by, r_x, r_y)) r_hit_b <= 1'b1;
          end else if (w_cur != '0) begin
            r_cell[r_y][r_x] <= w_cur + SW'(1);
          end
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + C_ONE;
          end else begin
            r_x <= r_x + C_ONE;
          end
        end
        S_DAMAGE: begin
          if (r_hit_a && (r_health_a != '0)) r_health_a <= r_health_a - HEALTH_W'(1);
          if (r_hit_b && (r_health_b != '0)) r_health_b <= r_health_b - HEALTH_W'(1);
        end
        S_RESOLVE: begin
          if ((r_health_a == '0) && (r_health_b == '0)) r_game <= 2'd3;
          else if (r_health_a == '0)                    r_game <= 2'd2;
          else if (r_health_b == '0)                    r_game <= 2'd1;
          else                                          r_game <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign health_a   = r_health_a;
  assign health_b   = r_health_b;
  assign game_state = r_game;

endmodule

// File: tb/tb_bomb_engine.sv
// Directed bench for bomb_engine: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_bomb_engine;

  localparam int GW = 10;
  localparam int GH = 10;
  localparam int CW = 4;
  localparam int FUSE = 3;
  localparam int RAD = 2;
  localparam int HW = 2;
  localparam int HI = 3;
  localparam int SW = $clog2(FUSE + 1);
  localparam int SCAN_LAT = GW * GH + 2;

  logic          bombClk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          place_a_valid = 1'b0;
  logic          place_b_valid = 1'b0;
  logic          place_a_ready;
  logic          place_b_ready;
  logic [CW-1:0] player_ax = '0;
  logic [CW-1:0] player_ay = '0;
  logic [CW-1:0] player_bx = '0;
  logic [CW-1:0] player_by = '0;
  logic [CW-1:0] rd_x = '0;
  logic [CW-1:0] rd_y = '0;
  logic [SW-1:0] rd_state;
  logic          rd_flame;
  logic [HW-1:0] health_a;
  logic [HW-1:0] health_b;
  logic [1:0]    game_state;
  logic          busy;
  logic          explode;

  bomb_engine #(
    .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .FUSE(FUSE),
    .RADIUS(RAD), .HEALTH_W(HW), .HEALTH_INIT(HI)
  ) dut (
    .bombClk(bombClk), .rst(rst), .tick(tick),
    .place_a_valid(place_a_valid), .place_a_ready(place_a_ready),
    .place_b_valid(place_b_valid), .place_b_ready(place_b_ready),
    .player_ax(player_ax), .player_ay(player_ay),
    .player_bx(player_bx), .player_by(player_by),
    .rd_x(rd_x), .rd_y(rd_y), .rd_state(rd_state), .rd_flame(rd_flame),
    .health_a(health_a), .health_b(health_b), .game_state(game_state),
    .busy(busy), .explode(explode)
  );

  always #5 bombClk = ~bombClk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic expect_v(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge bombClk);
    #1;
  endtask

  task automatic rd(input int x, input int y, output logic [31:0] st, output logic [31:0] fl);
    rd_x = x[CW-1:0];
    rd_y = y[CW-1:0];
    step();
    st = 32'(rd_state);
    fl = 32'(rd_flame);
  endtask

  task automatic set_pos(input int ax, input int ay, input int bx, input int by);
    player_ax = ax[CW-1:0];
    player_ay = ay[CW-1:0];
    player_bx = bx[CW-1:0];
    player_by = by[CW-1:0];
  endtask

  task automatic place(input logic a, input logic b);
    place_a_valid = a;
    place_b_valid = b;
    step();
    place_a_valid = 1'b0;
    place_b_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Waits (bounded) for busy to drop; counts cycles and explode pulses seen.
  task automatic wait_idle(output int cyc, output int expl);
    cyc = 0;
    expl = 0;
    while (busy && cyc < 400) begin
      if (explode) expl++;
      step();
      cyc++;
    end
    if (busy) begin
      total++;
      bad++;
      $error("FAIL idle_timeout observed=busy expected=idle");
    end
  endtask

  task automatic do_tick(output int cyc, output int expl);
    pulse_tick();
    wait_idle(cyc, expl);
  endtask

  task automatic three_ticks();
    int c;
    int e;
    for (int k = 0; k < 3; k++) do_tick(c, e);
  endtask

  initial begin
    logic [31:0] st;
    logic [31:0] fl;
    int          cyc;
    int          ex;
    int          miss;
    int          busy_cnt;
    logic        want;

    // Reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    expect_v("rst_health_a", HI);
    expect_v("rst_health_b", HI);
    expect_v("rst_game", 0);
    expect_v("rst_busy", 0);
    expect_v("rst_ready_a", 1);
    check_v(32'(health_a));
    check_v(32'(health_b));
    check_v(32'(game_state));
    check_v(32'(busy));
    check_v(32'(place_a_ready));

    // Single bomb lifecycle at (3,3), players out of reach.
    set_pos(3, 3, 8, 1);
    place(1'b1, 1'b0);
    set_pos(8, 8, 8, 1);
    expect_v("place_a_cell", 1);
    rd(3, 3, st, fl);
    check_v(st);

    expect_v("tick_latency", SCAN_LAT);
    expect_v("tick1_explode", 0);
    expect_v("tick1_cell", 2);
    do_tick(cyc, ex);
    check_v(32'(cyc));
    check_v(32'(ex));
    rd(3, 3, st, fl);
    check_v(st);

    expect_v("tick2_cell", 3);
    do_tick(cyc, ex);
    rd(3, 3, st, fl);
    check_v(st);

    expect_v("tick3_explode", 1);
    expect_v("tick3_cell", 0);
    expect_v("flame_1_3", 1);
    expect_v("flame_3_5", 1);
    expect_v("flame_map_miss", 0);
    expect_v("tick3_health_a", HI);
    do_tick(cyc, ex);
    check_v(32'(ex));
    rd(3, 3, st, fl);
    check_v(st);
    rd(1, 3, st, fl);
    check_v(fl);
    rd(3, 5, st, fl);
    check_v(fl);
    miss = 0;
    for (int y = 0; y < GH; y++) begin
      for (int x = 0; x < GW; x++) begin
        want = ((y == 3) && (x >= 1) && (x <= 5)) || ((x == 3) && (y >= 1) && (y <= 5));
        rd(x, y, st, fl);
        if (fl[0] !== want) miss++;
      end
    end
    check_v(32'(miss));
    check_v(32'(health_a));

    // Blast hits A along the column, B sits 3 cells away on the row.
    set_pos(3, 3, 6, 3);
    place(1'b1, 1'b0);
    set_pos(3, 5, 6, 3);
    expect_v("single_hit_health_a", 2);
    expect_v("single_hit_health_b", 3);
    three_ticks();
    check_v(32'(health_a));
    check_v(32'(health_b));

    // Two bombs on the same tick both cover A (and B): one point each.
    set_pos(3, 3, 5, 5);
    place(1'b1, 1'b1);
    expect_v("place_b_cell", 1);
    rd(5, 5, st, fl);
    check_v(st);
    set_pos(3, 5, 5, 3);
    expect_v("double_hit_health_a", 1);
    expect_v("double_hit_health_b", 2);
    expect_v("double_hit_game", 0);
    three_ticks();
    check_v(32'(health_a));
    check_v(32'(health_b));
    check_v(32'(game_state));

    // Bring B down to 1 with a bomb that misses A.
    set_pos(1, 1, 7, 7);
    place(1'b0, 1'b1);
    set_pos(1, 1, 7, 8);
    expect_v("b_only_health_b", 1);
    expect_v("b_only_health_a", 1);
    three_ticks();
    check_v(32'(health_b));
    check_v(32'(health_a));

    // Both hit at health 1 -> draw, then everything frozen.
    set_pos(4, 4, 8, 8);
    place(1'b1, 1'b0);
    set_pos(4, 6, 6, 4);
    expect_v("draw_health_a", 0);
    expect_v("draw_health_b", 0);
    expect_v("draw_game", 3);
    three_ticks();
    check_v(32'(health_a));
    check_v(32'(health_b));
    check_v(32'(game_state));

    expect_v("over_tick_busy", 0);
    pulse_tick();
    check_v(32'(busy));
    set_pos(2, 2, 8, 8);
    place_a_valid = 1'b1;
    #1;
    expect_v("over_ready_a", 0);
    check_v(32'(place_a_ready));
    step();
    place_a_valid = 1'b0;
    expect_v("over_place_cell", 0);
    expect_v("over_game", 3);
    rd(2, 2, st, fl);
    check_v(st);
    check_v(32'(game_state));

    // Reset restores health and play.
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_v("rst2_health_a", HI);
    expect_v("rst2_game", 0);
    expect_v("rst2_ready_b", 1);
    check_v(32'(health_a));
    check_v(32'(game_state));
    check_v(32'(place_b_ready));

    // Same-cell collision and border placement.
    set_pos(4, 4, 4, 4);
    place(1'b1, 1'b1);
    expect_v("collide_cell", 1);
    rd(4, 4, st, fl);
    check_v(st);
    set_pos(0, 4, 8, 8);
    place(1'b1, 1'b0);
    expect_v("border_cell", 0);
    rd(0, 4, st, fl);
    check_v(st);

    // Reset in the middle of a scan.
    set_pos(1, 4, 8, 8);
    pulse_tick();
    for (int k = 0; k < 20; k++) step();
    expect_v("midscan_busy", 1);
    check_v(32'(busy));
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_v("midscan_rst_busy", 0);
    expect_v("midscan_rst_health_a", HI);
    expect_v("midscan_rst_cell", 0);
    check_v(32'(busy));
    check_v(32'(health_a));
    rd(4, 4, st, fl);
    check_v(st);

    // Pending tick: second tick mid-scan runs one more scan, third is lost.
    set_pos(2, 2, 8, 8);
    place(1'b1, 1'b0);
    set_pos(8, 8, 8, 1);
    pulse_tick();
    for (int k = 0; k < 10; k++) step();
    pulse_tick();
    for (int k = 0; k < 10; k++) step();
    pulse_tick();
    wait_idle(cyc, ex);
    step();
    expect_v("pending_rescan_busy", 1);
    check_v(32'(busy));
    wait_idle(cyc, ex);
    expect_v("pending_cell", 3);
    rd(2, 2, st, fl);
    check_v(st);
    busy_cnt = 0;
    for (int k = 0; k < 150; k++) begin
      step();
      if (busy) busy_cnt++;
    end
    expect_v("lost_tick_busy_cycles", 0);
    check_v(32'(busy_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bomb_engine.md
Name: bomb_engine

Overview:
- Parametrised successor to the per-tick bomb updater.
- Owns the bomb map internally instead of taking it as a wire bundle.
- Accepts bomb placements from players A and B through a valid/ready handshake.
- On each 1 Hz tick, advances fuses, detonates bombs with a cross blast of configurable radius, applies damage and resolves game_state.
- Sits between the player controllers and the VGA renderer; the renderer reads cell state and flame through a combinational read port.

Parameters:
GRID_W, 10, columns incl. border walls (interior x = 1..GRID_W-2)
GRID_H, 10, rows incl. border walls (interior y = 1..GRID_H-2)
COORD_W, 4, coordinate width; 2**COORD_W >= max(GRID_W, GRID_H)
FUSE, 3, fuse value at which a bomb detonates on the next tick (>=2)
RADIUS, 2, blast reach in cells along row and column
HEALTH_W, 2, health counter width
HEALTH_INIT, 3, health after reset

Ports:
bombClk  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous active-high reset
tick  in  1  single-cycle fuse-advance strobe (1 Hz enable)
place_a_valid  in  1  player A requests a bomb at (player_ax, player_ay)
place_a_ready  out  1  placement A accepted when valid&&ready
place_b_valid  in  1  player B request
place_b_ready  out  1  placement B ready
player_ax, player_ay, player_bx, player_by  in  COORD_W  player positions
rd_x, rd_y  in  COORD_W  render read address
rd_state  out  clog2(FUSE+1)  fuse value at (rd_x, rd_y); 0 = empty; 0 if out of grid
rd_flame  out  1  cell lies in a blast from the most recent completed tick
health_a, health_b  out  HEALTH_W  current health
game_state  out  2  0 playing, 1 A wins, 2 B wins, 3 draw
busy  out  1  FSM not in IDLE
explode  out  1  one-cycle pulse at end of a scan that detonated >=1 bomb

Behaviour:
- Reset (sync, bombClk edge with rst=1), from any state including mid-scan:
  - all cells 0, all flames 0, health_a = health_b = HEALTH_INIT
  - game_state = 0, FSM = IDLE, pending tick cleared, explode = 0
- FSM states: IDLE, SCAN, DAMAGE, RESOLVE.
- IDLE:
  - place_x_ready = 1 iff game_state == 0; both ready = 0 in all other states.
  - Accepted placement: target must be interior and cell 0, else dropped silently; target cell becomes 1.
  - A and B on the same cell in the same cycle: A's bomb written, B dropped.
  - tick, or pending tick set, with game_state == 0 -> SCAN, index 0, clear all flame bits, clear hit flags, clear pending.
  - A placement accepted in the same cycle as scan start is advanced by that scan (1 -> 2).
- SCAN: one cell per cycle in row-major order, GRID_W*GRID_H cycles.
  - border cells: forced 0
  - cell 0: unchanged
  - 0 < cell < FUSE: cell + 1
  - cell == FUSE: cell <- 0; set flame on every in-grid cell within RADIUS along the row and column (no wrap); set hit_a if (ax == x && |ay-y| <= RADIUS) || (ay == y && |ax-x| <= RADIUS); same rule for hit_b.
  - Absolute differences are computed unsigned without underflow (compare max-min).
  - Last cell -> DAMAGE.
- DAMAGE (1 cycle):
  - Each player loses at most 1 health per tick however many blasts hit; saturates at 0.
  - explode pulses this cycle if any detonation occurred.
- RESOLVE (1 cycle):
  - Evaluated on the post-damage health: both 0 -> 3; health_a 0 -> 2; health_b 0 -> 1; else stays 0.
  - -> IDLE.
- Tick latency: GRID_W*GRID_H + 2 cycles from scan start until back in IDLE.
- tick while busy sets a 1-deep pending flag; further ticks while pending are lost.
- game_state != 0 is sticky until reset: ticks and placements are ignored, and the map, flames and health freeze.
- Read port: purely combinational, valid every cycle; during SCAN it may show a mix of old and new values.

Test Plan:
- Reset, then place A at (3,3), three ticks -> after each completed scan rd_state at (3,3) = 2, 3, 0; after the third, rd_flame = 1 at (1..5,3) and (3,1..5), explode pulses once.
- Bomb at (3,3), player A at (3,5), player B at (6,3); detonate -> health_a 3 -> 2, health_b unchanged 3.
- Two bombs both covering A, detonating on the same tick -> health_a decrements by exactly 1.
- A and B both with health 1, both hit on the same tick -> both 0, game_state = 3; later ticks and place_a_valid leave map and game_state unchanged, place_a_ready = 0.
- Second tick asserted mid-SCAN -> exactly one extra scan runs immediately after RESOLVE; third tick in the same window is lost.
- Simultaneous place A and B at the same interior cell -> cell = 1, one bomb only; placement at border (0,4) -> dropped; rst asserted mid-SCAN -> map cleared, health = 3, busy = 0 next cycle.
